// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: round-robin multi-approach traffic-light sequencer.
// Each approach gets green, yellow and all-red phases in turn, with
// cycle-counted durations. The optional pedestrian walk phase (per-approach
// request latch, WALK state, WalkLamp) is built only when TLC_WALK_EN is
// defined. Otherwise Walk is ignored and WalkPend/WalkLamp read 0.
module traffic_light_ctrl #(
    parameter int N_DIR      = 2,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 5,
    parameter int CNT_W      = 16,
    localparam int DW        = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Hold,
    input  logic [N_DIR-1:0]   Walk,
    output logic [3*N_DIR-1:0] Lamps,
    output logic [N_DIR-1:0]   WalkLamp,
    output logic [N_DIR-1:0]   WalkPend,
    output logic [DW-1:0]      Dir
);

    typedef enum logic [2:0] {
        S_RESET,
        S_GREEN,
        S_YELLOW,
        S_ALLRED,
        S_WALK
    } state_t;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] LD_G = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_Y = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_A = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] LD_W = CNT_W'(WALK_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    dir_nxt;
    logic             expire;
    logic             walk_go;

    assign dir_nxt = (Dir == DW'(N_DIR - 1)) ? '0 : Dir + DW'(1);
    assign expire  = (cnt == '0) && !Hold;

`ifdef TLC_WALK_EN
    logic [N_DIR-1:0] walk_clr;

    // ALL_RED of an approach with a pending request diverts into its WALK.
    assign walk_go  = (state == S_ALLRED) && expire && WalkPend[Dir];
    assign walk_clr = walk_go ? (N_DIR'(1) << Dir) : '0;

    // Request latch: keeps running during Hold; the entry clear beats a same-cycle press.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) WalkPend <= '0;
        else       WalkPend <= (WalkPend | Walk) & ~walk_clr;
    end

    assign WalkLamp = (state == S_WALK) ? (N_DIR'(1) << Dir) : '0;
`else
    logic unused_walk;

    assign walk_go     = 1'b0;
    assign WalkPend    = '0;
    assign WalkLamp    = '0;
    assign unused_walk = ^Walk;
`endif

    // Phase sequencer: counts the current phase down, steps on expiry, frozen by Hold.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_RESET;
            Dir   <= '0;
            cnt   <= '0;
        end else if (!Hold) begin
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else begin
                case (state)
                    S_RESET: begin
                        state <= S_GREEN;
                        Dir   <= '0;
                        cnt   <= LD_G;
                    end
                    S_GREEN: begin
                        state <= S_YELLOW;
                        cnt   <= LD_Y;
                    end
                    S_YELLOW: begin
                        state <= S_ALLRED;
                        cnt   <= LD_A;
                    end
                    S_ALLRED: begin
                        if (walk_go) begin
                            state <= S_WALK;
                            cnt   <= LD_W;
                        end else begin
                            state <= S_GREEN;
                            Dir   <= dir_nxt;
                            cnt   <= LD_G;
                        end
                    end
                    S_WALK: begin
                        state <= S_GREEN;
                        Dir   <= dir_nxt;
                        cnt   <= LD_G;
                    end
                    default: begin
                        state <= S_RESET;
                        Dir   <= '0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Lamp decode: everything red except the served approach in GREEN/YELLOW.
    always_comb begin
        Lamps = {N_DIR{3'b100}};
        for (int i = 0; i < N_DIR; i++) begin
            if (Dir == DW'(i)) begin
                if (state == S_GREEN)       Lamps[3*i +: 3] = 3'b001;
                else if (state == S_YELLOW) Lamps[3*i +: 3] = 3'b010;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl at default parameters (N_DIR=2).
// Stimulus pushes the hand-computed expected outputs for every cycle into a
// queue; a monitor on the falling edge pops and compares them.
module tb_traffic_light_ctrl;

    logic       Clk;
    logic       Reset;
    logic       Hold;
    logic [1:0] Walk;
    logic [5:0] Lamps;
    logic [1:0] WalkLamp;
    logic [1:0] WalkPend;
    logic [0:0] Dir;

    // Lamps = {approach1 RYG, approach0 RYG}
    localparam logic [5:0] ALLR = 6'b100_100;
    localparam logic [5:0] G0   = 6'b100_001;
    localparam logic [5:0] Y0   = 6'b100_010;
    localparam logic [5:0] G1   = 6'b001_100;
    localparam logic [5:0] Y1   = 6'b010_100;

`ifdef TLC_WALK_EN
    localparam logic [1:0] WP0 = 2'b01;
`else
    localparam logic [1:0] WP0 = 2'b00;
`endif

    typedef struct {
        logic [5:0] lamps;
        logic       dir;
        logic [1:0] wl;
        logic [1:0] wp;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    traffic_light_ctrl dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Hold     (Hold),
        .Walk     (Walk),
        .Lamps    (Lamps),
        .WalkLamp (WalkLamp),
        .WalkPend (WalkPend),
        .Dir      (Dir)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a lamp state, compare it with the queue head.
    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, ".lamps"}, {2'b00, Lamps}, {2'b00, e.lamps});
            chk({e.tag, ".dir"},   {7'b0, Dir},    {7'b0, e.dir});
            chk({e.tag, ".wlamp"}, {6'b0, WalkLamp}, {6'b0, e.wl});
            chk({e.tag, ".wpend"}, {6'b0, WalkPend}, {6'b0, e.wp});
        end
    end

    // Expect n consecutive cycles of the given outputs; called at posedge+1.
    task automatic seg(input logic [5:0] l, input logic d, input logic [1:0] wl,
                       input logic [1:0] wp, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.lamps = l;
            e.dir   = d;
            e.wl    = wl;
            e.wp    = wp;
            e.tag   = tag;
            q.push_back(e);
            @(posedge Clk);
            #1;
        end
    endtask

    // One full walk-free round (26 cycles) with a constant WalkPend expectation.
    task automatic round(input logic [1:0] wp, input string tag);
        seg(G0,   1'b0, 2'b00, wp, 8, {tag, ".g0"});
        seg(Y0,   1'b0, 2'b00, wp, 3, {tag, ".y0"});
        seg(ALLR, 1'b0, 2'b00, wp, 2, {tag, ".r0"});
        seg(G1,   1'b1, 2'b00, wp, 8, {tag, ".g1"});
        seg(Y1,   1'b1, 2'b00, wp, 3, {tag, ".y1"});
        seg(ALLR, 1'b1, 2'b00, wp, 2, {tag, ".r1"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Hold  = 1'b0;
        Walk  = 2'b00;
        @(posedge Clk);
        #1;
        seg(ALLR, 1'b0, 2'b00, 2'b00, 1, "rst");
        Reset = 1'b0;
        seg(ALLR, 1'b0, 2'b00, 2'b00, 1, "rst_rel");
        round(2'b00, "plain");

`ifdef TLC_WALK_EN
        // Single Walk[1] pulse during approach-0 green: 31-cycle round.
        Walk = 2'b10;
        seg(G0, 1'b0, 2'b00, 2'b00, 1, "pulse.g0a");
        Walk = 2'b00;
        seg(G0,   1'b0, 2'b00, 2'b10, 7, "pulse.g0");
        seg(Y0,   1'b0, 2'b00, 2'b10, 3, "pulse.y0");
        seg(ALLR, 1'b0, 2'b00, 2'b10, 2, "pulse.r0");
        seg(G1,   1'b1, 2'b00, 2'b10, 8, "pulse.g1");
        seg(Y1,   1'b1, 2'b00, 2'b10, 3, "pulse.y1");
        seg(ALLR, 1'b1, 2'b00, 2'b10, 2, "pulse.r1");
        seg(ALLR, 1'b1, 2'b10, 2'b00, 5, "pulse.walk1");

        // Hold 4 cycles mid-green with a Walk[0] press during Hold.
        seg(G0, 1'b0, 2'b00, 2'b00, 3, "hold.g0pre");
        Hold = 1'b1;
        seg(G0, 1'b0, 2'b00, 2'b00, 1, "hold.h1");
        Walk = 2'b01;
        seg(G0, 1'b0, 2'b00, 2'b00, 1, "hold.h2");
        Walk = 2'b00;
        seg(G0, 1'b0, 2'b00, 2'b01, 2, "hold.h34");
        Hold = 1'b0;
        seg(G0,   1'b0, 2'b00, 2'b01, 5, "hold.g0post");
        seg(Y0,   1'b0, 2'b00, 2'b01, 3, "hold.y0");
        seg(ALLR, 1'b0, 2'b00, 2'b01, 2, "hold.r0");
        seg(ALLR, 1'b0, 2'b01, 2'b00, 5, "hold.walk0");
        seg(G1,   1'b1, 2'b00, 2'b00, 8, "hold.g1");
        seg(Y1,   1'b1, 2'b00, 2'b00, 3, "hold.y1");
        seg(ALLR, 1'b1, 2'b00, 2'b00, 2, "hold.r1");

        // Walk[1] held: served every round, latch re-sets right after WALK entry.
        Walk = 2'b10;
        seg(G0,   1'b0, 2'b00, 2'b00, 1, "cont.g0a");
        seg(G0,   1'b0, 2'b00, 2'b10, 7, "cont.g0");
        seg(Y0,   1'b0, 2'b00, 2'b10, 3, "cont.y0");
        seg(ALLR, 1'b0, 2'b00, 2'b10, 2, "cont.r0");
        seg(G1,   1'b1, 2'b00, 2'b10, 8, "cont.g1");
        seg(Y1,   1'b1, 2'b00, 2'b10, 3, "cont.y1");
        seg(ALLR, 1'b1, 2'b00, 2'b10, 2, "cont.r1");
        seg(ALLR, 1'b1, 2'b10, 2'b00, 1, "cont.wclr");
        seg(ALLR, 1'b1, 2'b10, 2'b10, 4, "cont.wset");
        round(2'b10, "cont2");
        Walk = 2'b00;
        seg(ALLR, 1'b1, 2'b10, 2'b00, 5, "cont2.walk1");
`else
        // Walk ignored: constant presses change nothing, period stays 26.
        Walk = 2'b11;
        round(2'b00, "nowalk1");
        round(2'b00, "nowalk2");
        Walk = 2'b00;

        // Hold 4 cycles mid-green stretches green to 12 cycles.
        seg(G0, 1'b0, 2'b00, 2'b00, 3, "hold.g0pre");
        Hold = 1'b1;
        seg(G0, 1'b0, 2'b00, 2'b00, 1, "hold.h1");
        Walk = 2'b01;
        seg(G0, 1'b0, 2'b00, 2'b00, 1, "hold.h2");
        Walk = 2'b00;
        seg(G0, 1'b0, 2'b00, 2'b00, 2, "hold.h34");
        Hold = 1'b0;
        seg(G0,   1'b0, 2'b00, 2'b00, 5, "hold.g0post");
        seg(Y0,   1'b0, 2'b00, 2'b00, 3, "hold.y0");
        seg(ALLR, 1'b0, 2'b00, 2'b00, 2, "hold.r0");
        seg(G1,   1'b1, 2'b00, 2'b00, 8, "hold.g1");
        seg(Y1,   1'b1, 2'b00, 2'b00, 3, "hold.y1");
        seg(ALLR, 1'b1, 2'b00, 2'b00, 2, "hold.r1");
`endif

        // Asynchronous reset on the second yellow cycle, with a request pending.
        Walk = 2'b01;
        seg(G0, 1'b0, 2'b00, 2'b00, 1, "arst.g0a");
        Walk = 2'b00;
        seg(G0, 1'b0, 2'b00, WP0, 7, "arst.g0");
        seg(Y0, 1'b0, 2'b00, WP0, 1, "arst.y0");
        Reset = 1'b1;
        seg(ALLR, 1'b0, 2'b00, 2'b00, 1, "arst.async");
        Reset = 1'b0;
        seg(ALLR, 1'b0, 2'b00, 2'b00, 1, "arst.rel");
        round(2'b00, "after_rst");

        @(negedge Clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised multi-approach traffic-light sequencer for the lab board. It cycles round-robin through N_DIR vehicle approaches with cycle-counted green, yellow and all-red phases. Pedestrian requests are latched per approach and served in a dedicated walk phase. It drives the board LEDs directly and replaces the single-approach fixed controller.

## Interface
Parameters:
- N_DIR, 2: number of approaches, legal 2..8
- GREEN_CYC, 8: green duration in Clk cycles, ≥1
- YELLOW_CYC, 3: yellow duration in cycles, ≥1
- ALLRED_CYC, 2: all-red clearance duration in cycles, ≥1
- WALK_CYC, 5: pedestrian walk duration in cycles, ≥1
- CNT_W, 16: phase counter width; every duration must be ≤ 2^CNT_W

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- Hold  in  1  freeze: state, direction and counter hold while high
- Walk  in  N_DIR  pedestrian buttons, level, one per approach
- Lamps  out  3*N_DIR  per-approach lamps; Lamps[3d+2:3d] = {R,Y,G}
- WalkLamp  out  N_DIR  walk indicator per approach
- WalkPend  out  N_DIR  latched, not-yet-served walk requests
- Dir  out  max(1,$clog2(N_DIR))  approach currently served

## Operation
- States: RESET, GREEN, YELLOW, ALL_RED, WALK.
- RESET: all Lamps red, WalkLamp 0, Dir 0. Next edge goes to GREEN with Dir=0.
- GREEN(d): Lamps[d] = G; all other approaches R. When the counter expires, go to YELLOW.
- YELLOW(d): Lamps[d] = Y; others R. On expiry, go to ALL_RED.
- ALL_RED(d): every approach R. On expiry:
  - if WalkPend[d], go to WALK(d);
  - otherwise go to GREEN((d+1) mod N_DIR).
- WALK(d): every approach R and WalkLamp[d]=1. On expiry, go to GREEN((d+1) mod N_DIR).
- Walk latch: WalkPend[i] is set in any cycle Walk[i]=1. WalkPend[d] is cleared on the edge entering WALK(d).
  - Simultaneous set and clear on WalkPend[d]: clear wins.
  - The latch operates during Hold.
- Counter: loads duration-1 on state entry and decrements each cycle. The transition occurs on the edge where the counter is 0 and Hold=0.
- Hold=1: state, Dir and counter are frozen. Lamps stay unchanged.
- Lamp decode is combinational from the registered state and Dir. Outputs are therefore glitch-free relative to Clk edges. Exactly one of R/Y/G is high per approach at all times.
- Dir wraps from N_DIR-1 to 0.

## Timing
- Reset values: state RESET, Dir 0, counter 0, WalkPend 0, WalkLamp 0, Lamps all {1,0,0}.
- Reset is asynchronous. Asserting it mid-phase forces the reset values immediately, without waiting for an edge.
- The first GREEN begins on the first Clk edge after Reset deasserts with Hold=0.
- Phase lengths are exact: GREEN lasts GREEN_CYC cycles, YELLOW lasts YELLOW_CYC, ALL_RED lasts ALLRED_CYC, WALK lasts WALK_CYC. Each Hold-high cycle extends the current phase by one cycle.
- Walk-to-WalkPend latency: 1 cycle (registered).
- Full round with no walks: N_DIR*(GREEN_CYC+YELLOW_CYC+ALLRED_CYC) cycles.

## Configuration
- TLC_WALK_EN defined: pedestrian latch, WALK state and WalkLamp are implemented as described above.
- TLC_WALK_EN undefined:
  - Walk is ignored.
  - WalkPend and WalkLamp are tied to 0.
  - WALK is unreachable; ALL_RED always goes to the next approach's GREEN.
  - Port list is unchanged.

## Test plan
- N_DIR=2, defaults, no Walk → approach 0 G for 8 cycles, Y 3, all-R 2, then approach 1 G for 8, Y 3, all-R 2. Period 26 cycles; no two approaches non-red simultaneously.
- Walk[1] pulsed 1 cycle during approach-0 green:
  - WalkPend=2'b10 the next cycle.
  - After approach 1's all-red, WalkLamp=2'b10 for 5 cycles with all lamps red; WalkPend clears on WALK entry.
  - Then approach 0 goes green. Period is 31 cycles.
- Reset asserted on the second YELLOW cycle → Lamps all red and WalkPend=0 with no Clk edge. After release, approach 0 goes green on the first edge.
- Hold high for 4 cycles mid-green → green lasts 12 cycles, then normal sequence. A Walk[0] press during Hold still sets WalkPend[0].
- Walk[1] held high continuously:
  - WalkPend[1] clears on the WALK(1) entry edge and re-sets on the next cycle.
  - WALK(1) is served again on every round.
- Build without TLC_WALK_EN, Walk=2'b11 constant → WalkPend=WalkLamp=0 and period stays 26 cycles.
